// File: rtl/regfile_mm_stream.sv
// regfile_mm_stream: wide operand/result register file for the MM datapath.
// Registers are loaded over a narrow BUS_W valid/ready stream. Beats collect in a
// staging register and are committed in one cycle. The accumulator register
// can take lane-wise wrapping accumulate writes and can be flushed with stc.
//
// state  | meaning
// IDLE   | waiting for the first beat; latches addr/acc with beat 0
// LOAD   | collecting beats 1..BEATS-1; holds while ld_valid is low
// COMMIT | one cycle with ld_ready low; staging written (or dropped on bad addr)
module regfile_mm_stream #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 256,
  parameter int BUS_W    = 64,
  parameter int LANE_W   = 16,
  parameter int ACC_IDX  = NUM_REGS - 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [AW-1:0]              ld_addr,
  input  logic                       ld_acc,
  input  logic [BUS_W-1:0]           ld_data,
  input  logic                       stc,
  output logic                       wr_done,
  output logic                       ld_err,
  output logic [NUM_REGS-1:0]        reg_valid,
  output logic [NUM_REGS*DATA_W-1:0] rd_flat
);

  localparam int BEATS = DATA_W / BUS_W;
  localparam int LANES = DATA_W / LANE_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [AW:0]   NUM_REGS_W = (AW + 1)'(NUM_REGS);
  localparam logic [AW-1:0] ACC_A      = AW'(ACC_IDX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [AW-1:0]                    r_addr;
  logic                             r_acc;
  logic [CW-1:0]                    r_beat_cnt;
  logic [DATA_W-1:0]                r_stage;
  logic [NUM_REGS-1:0][DATA_W-1:0]  r_regs;
  logic [NUM_REGS-1:0]              r_reg_valid;

  logic              w_accept;
  logic [CW-1:0]     w_beat_idx;
  logic              w_addr_ok;
  logic              w_acc_hit;
  logic [DATA_W-1:0] w_acc_base;
  logic [DATA_W-1:0] w_acc_sum;

  assign w_addr_ok = ({1'b0, r_addr} < NUM_REGS_W);
  assign w_acc_hit = r_acc && (r_addr == ACC_A);
  // A same-cycle flush zeroes the accumulate base, so the commit yields 0+stage.
  assign w_acc_base = stc ? '0 : r_regs[ACC_IDX];

  assign rd_flat   = r_regs;
  assign reg_valid = r_reg_valid;

  // Lane-wise wrapping add of staging onto the accumulator; no inter-lane carry.
  always_comb begin
    w_acc_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      w_acc_sum[l*LANE_W +: LANE_W] = w_acc_base[l*LANE_W +: LANE_W]
                                    + r_stage[l*LANE_W +: LANE_W];
    end
  end

  // Next-state and handshake/pulse outputs.
  always_comb begin
    w_state_nxt = r_state;
    ld_ready    = 1'b1;
    wr_done     = 1'b0;
    ld_err      = 1'b0;
    w_accept    = 1'b0;
    w_beat_idx  = r_beat_cnt;
    case (r_state)
      IDLE: begin
        w_accept   = ld_valid;
        w_beat_idx = '0;
        if (ld_valid) begin
          w_state_nxt = (BEATS == 1) ? COMMIT : LOAD;
        end
      end
      LOAD: begin
        w_accept = ld_valid;
        if (ld_valid && (r_beat_cnt == LAST_BEAT)) begin
          w_state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        ld_ready    = 1'b0;
        wr_done     = w_addr_ok;
        ld_err      = ~w_addr_ok;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register, beat staging, flush and commit; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_acc       <= 1'b0;
      r_beat_cnt  <= '0;
      r_stage     <= '0;
      r_regs      <= '0;
      r_reg_valid <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        if (r_state == IDLE) begin
          r_addr     <= ld_addr;
          r_acc      <= ld_acc;
          r_beat_cnt <= CW'(1);
        end else begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
        for (int k = 0; k < BEATS; k++) begin
          if (w_beat_idx == CW'(k)) begin
            r_stage[k*BUS_W +: BUS_W] <= ld_data;
          end
        end
      end

      if (r_state == COMMIT) begin
        r_beat_cnt <= '0;
      end

      // Flush first; a commit to the same register below takes precedence.
      if (stc) begin
        r_regs[ACC_IDX]      <= '0;
        r_reg_valid[ACC_IDX] <= 1'b0;
      end

      if ((r_state == COMMIT) && w_addr_ok) begin
        r_regs[r_addr]      <= w_acc_hit ? w_acc_sum : r_stage;
        r_reg_valid[r_addr] <= 1'b1;
      end
    end
  end

endmodule
